// File: rtl/inst_encoder_pkg.sv
// -----------------------------------------------------------------------------
// inst_encoder_pkg
// Shared opcode header for the RV64I instruction encoder. It holds the
// instruction format codes, the major opcodes used by the encoder's clients,
// the canonical NOP word and the field bundle that is captured in stage S1.
// It also provides a helper that tests whether a 64-bit immediate is the sign
// extension of its low w bits.
// No ports (package).
// -----------------------------------------------------------------------------
package inst_encoder_pkg;

    typedef enum logic [3:0] {
        FMT_R = 4'd0,
        FMT_I = 4'd1,
        FMT_S = 4'd2,
        FMT_B = 4'd3,
        FMT_U = 4'd4,
        FMT_J = 4'd5
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [3:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [63:0] imm;
    } enc_fields_t;

    // True when v equals the sign extension of v[w-1:0]. The shift pair
    // drops the upper bits and then replicates bit w-1 back over them.
    function automatic logic sext_fits(input logic [63:0] v, input int w);
        logic signed [63:0] s;
        s = $signed(v << (64 - w)) >>> (64 - w);
        return (s == $signed(v));
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// -----------------------------------------------------------------------------
// inst_encoder_if
// Valid/ready bus between an instruction producer and inst_encoder.
//   in_*      : field channel (producer -> encoder), handshake in_valid/in_ready
//   out_*     : encoded word channel (encoder -> consumer), handshake
//               out_valid/out_ready
// Modports: master = producer/consumer side, slave = encoder side.
// -----------------------------------------------------------------------------
interface inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [6:0]  in_funct7;
    logic [63:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_funct3, in_rs1, in_rs2,
               in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_funct3, in_rs1, in_rs2,
               in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );
endinterface

// File: rtl/inst_enc_pack.sv
// -----------------------------------------------------------------------------
// inst_enc_pack
// Combinational packer: places opcode/register/funct fields and the immediate
// into a 32-bit RV64I word according to the format code, and checks that the
// immediate is exactly representable in that format.
//   f    in   enc_fields_t   captured fields
//   inst out  32             packed word, NOP_INST when err
//   err  out  1              immediate out of range or format code illegal
// -----------------------------------------------------------------------------
module inst_enc_pack
    import inst_encoder_pkg::*;
(
    input  enc_fields_t f,
    output logic [31:0] inst,
    output logic        err
);

    logic [31:0] packed_word;
    logic        legal;

    // Branch and jump offsets are stored without bit 0, so an odd offset
    // cannot be represented even when it is otherwise in range.
    always_comb begin
        packed_word = '0;
        legal       = 1'b0;
        case (f.fmt)
            FMT_R: begin
                packed_word = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
                legal       = 1'b1;
            end
            FMT_I: begin
                packed_word = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
                legal       = sext_fits(f.imm, 12);
            end
            FMT_S: begin
                packed_word = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
                legal       = sext_fits(f.imm, 12);
            end
            FMT_B: begin
                packed_word = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                               f.imm[4:1], f.imm[11], f.opcode};
                legal       = sext_fits(f.imm, 13) && !f.imm[0];
            end
            FMT_U: begin
                packed_word = {f.imm[31:12], f.rd, f.opcode};
                legal       = (f.imm[11:0] == 12'h000) && sext_fits(f.imm, 32);
            end
            FMT_J: begin
                packed_word = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12],
                               f.rd, f.opcode};
                legal       = sext_fits(f.imm, 21) && !f.imm[0];
            end
            default: legal = 1'b0;
        endcase
        inst = legal ? packed_word : NOP_INST;
        err  = !legal;
    end

endmodule

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
// Streaming RV64I instruction encoder, 2-stage valid/ready pipeline.
// S1 captures the input fields; inst_enc_pack packs them and range-checks the
// immediate; S2 holds the packed word and error flag for the consumer.
// Latency 2 cycles, throughput 1 word/cycle.
//   clk       in   1      clock, rising edge
//   rstn      in   1      synchronous active-low reset
//   bus       slave      inst_encoder_if (field input + word output channels)
//   stat_enc  out  CNT_W  words delivered (INST_ENC_STATS_EN only)
//   stat_err  out  CNT_W  error words delivered (INST_ENC_STATS_EN only)
// Optional feature macro: INST_ENC_STATS_EN adds the CNT_W parameter and the
// saturating statistics counters.
// -----------------------------------------------------------------------------
module inst_encoder
    import inst_encoder_pkg::*;
`ifdef INST_ENC_STATS_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic          clk,
    input  logic          rstn,
    inst_encoder_if.slave bus
`ifdef INST_ENC_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_enc,
    output logic [CNT_W-1:0] stat_err
`endif
);

    enc_fields_t s1_q, s1_d;
    logic        s1_valid_q, s1_valid_d;
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_inst_q, s2_inst_d;
    logic        s2_err_q, s2_err_d;
    logic        s1_adv, s2_adv;
    logic [31:0] pack_inst;
    logic        pack_err;

    inst_enc_pack u_pack (
        .f    (s1_q),
        .inst (pack_inst),
        .err  (pack_err)
    );

    // A stage may load whenever it is empty or its contents move on this
    // cycle, so a full pipe can accept and deliver in the same cycle.
    // Data registers only load alongside a valid word, which keeps S2 stable
    // while the consumer stalls.
    always_comb begin
        s2_adv     = !s2_valid_q || bus.out_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        s2_inst_d  = s2_inst_q;
        s2_err_d   = s2_err_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_inst_d = pack_inst;
                s2_err_d  = pack_err;
            end
        end
        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_d.fmt    = bus.in_fmt;
                s1_d.opcode = bus.in_opcode;
                s1_d.rd     = bus.in_rd;
                s1_d.funct3 = bus.in_funct3;
                s1_d.rs1    = bus.in_rs1;
                s1_d.rs2    = bus.in_rs2;
                s1_d.funct7 = bus.in_funct7;
                s1_d.imm    = bus.in_imm;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_inst_q  <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_inst_q  <= s2_inst_d;
            s2_err_q   <= s2_err_d;
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_inst  = s2_inst_q;
    assign bus.out_err   = s2_err_q;

`ifdef INST_ENC_STATS_EN
    logic [CNT_W-1:0] stat_enc_q, stat_enc_d;
    logic [CNT_W-1:0] stat_err_q, stat_err_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stat_enc_d = stat_enc_q;
        stat_err_d = stat_err_q;
        if (s2_valid_q && bus.out_ready) begin
            if (stat_enc_q != '1) begin
                stat_enc_d = stat_enc_q + CNT_W'(1);
            end
            if (s2_err_q && (stat_err_q != '1)) begin
                stat_err_d = stat_err_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stat_enc_q <= '0;
            stat_err_q <= '0;
        end else begin
            stat_enc_q <= stat_enc_d;
            stat_err_q <= stat_err_d;
        end
    end

    assign stat_enc = stat_enc_q;
    assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_inst_encoder
// Self-checking bench for inst_encoder: directed vector table, backpressure
// and mid-transfer reset sequences, then a randomized stream checked by
// decoding each delivered word back to its fields and immediate.
// -----------------------------------------------------------------------------
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    inst_encoder_if bus ();

`ifdef INST_ENC_STATS_EN
    logic [15:0] stat_enc;
    logic [15:0] stat_err;
`endif

    inst_encoder dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
`ifdef INST_ENC_STATS_EN
        ,
        .stat_enc (stat_enc),
        .stat_err (stat_err)
`endif
    );

    typedef struct {
        logic [3:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic        err;
    } rec_t;

    typedef struct {
        rec_t        rec;
        logic [31:0] exp_inst;
    } vec_t;

    int vectors     = 0;
    int miscompares = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Representability from the numeric range of each format.
    function automatic logic refErr(input logic [3:0] fmt, input longint imm);
        case (fmt)
            FMT_R:        return 1'b0;
            FMT_I, FMT_S: return !(imm >= -2048 && imm <= 2047);
            FMT_B:        return !(imm >= -4096 && imm <= 4094 && (imm % 2) == 0);
            FMT_U:        return !((imm % 4096) == 0 && imm >= -64'sd2147483648 &&
                                   imm <= 64'sd2147483647);
            FMT_J:        return !(imm >= -1048576 && imm <= 1048574 && (imm % 2) == 0);
            default:      return 1'b1;
        endcase
    endfunction

    function automatic rec_t mkRec(input logic [3:0] fmt, input logic [6:0] op,
                                   input logic [4:0] rd, input logic [2:0] f3,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [6:0] f7, input logic [63:0] imm);
        rec_t r;
        r.fmt = fmt; r.op = op; r.rd = rd; r.f3 = f3;
        r.rs1 = rs1; r.rs2 = rs2; r.f7 = f7; r.imm = imm;
        r.err = refErr(fmt, imm);
        return r;
    endfunction

    function automatic vec_t mkVec(input rec_t r, input logic [31:0] exp_inst);
        vec_t v;
        v.rec      = r;
        v.exp_inst = exp_inst;
        return v;
    endfunction

    task automatic driveRec(input rec_t r);
        bus.in_fmt    = r.fmt;
        bus.in_opcode = r.op;
        bus.in_rd     = r.rd;
        bus.in_funct3 = r.f3;
        bus.in_rs1    = r.rs1;
        bus.in_rs2    = r.rs2;
        bus.in_funct7 = r.f7;
        bus.in_imm    = r.imm;
    endtask

    function automatic rec_t randRec();
        logic [31:0] a;
        logic [63:0] imm;
        logic [3:0]  fmt;
        a = $urandom;
        case ($urandom_range(0, 5))
            0: imm = {$urandom, $urandom};
            1: imm = {{52{a[11]}}, a[11:0]};
            2: imm = {{51{a[12]}}, a[12:1], 1'b0};
            3: imm = {{43{a[20]}}, a[20:1], 1'b0};
            4: imm = {{32{a[31]}}, a[31:12], 12'h000};
            default: begin
                case ($urandom_range(0, 9))
                    0: imm = 64'd2047;
                    1: imm = 64'd2048;
                    2: imm = -64'sd2048;
                    3: imm = -64'sd2049;
                    4: imm = 64'd4094;
                    5: imm = 64'd4096;
                    6: imm = 64'd1048574;
                    7: imm = -64'sd1048576;
                    8: imm = 64'h0000_0000_7FFF_F000;
                    default: imm = 64'h0000_0000_8000_0000;
                endcase
            end
        endcase
        if ($urandom_range(0, 9) < 8) fmt = 4'($urandom_range(0, 5));
        else                          fmt = 4'($urandom_range(6, 15));
        return mkRec(fmt, 7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom),
                     5'($urandom), 7'($urandom), imm);
    endfunction

    // Decode the delivered word and compare it with the fields that went in.
    task automatic checkWord(input rec_t e);
        logic [31:0]        w;
        logic [31:0]        fexp;
        logic [31:0]        fmask;
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic signed [31:0] u32;
        logic signed [20:0] j21;
        longint             dimm;
        w = bus.out_inst;
        checkOutput("rand_err", bus.out_err, e.err);
        if (e.err) begin
            checkOutput("rand_nop", w, 32'h0000_0013);
        end else begin
            dimm  = 0;
            fmask = 32'h0000_007F;
            fexp  = {25'd0, e.op};
            case (e.fmt)
                FMT_R: begin
                    fmask = 32'hFFFF_FFFF;
                    fexp  = {e.f7, e.rs2, e.rs1, e.f3, e.rd, e.op};
                end
                FMT_I: begin
                    fmask = 32'h000F_FFFF;
                    fexp  = (32'(e.rs1) << 15) | (32'(e.f3) << 12) | (32'(e.rd) << 7) | 32'(e.op);
                    i12   = w[31:20];
                    dimm  = i12;
                end
                FMT_S, FMT_B: begin
                    fmask = 32'h01FF_F07F;
                    fexp  = (32'(e.rs2) << 20) | (32'(e.rs1) << 15) | (32'(e.f3) << 12) | 32'(e.op);
                    if (e.fmt == FMT_S) begin
                        i12  = {w[31:25], w[11:7]};
                        dimm = i12;
                    end else begin
                        b13  = {w[31], w[7], w[30:25], w[11:8], 1'b0};
                        dimm = b13;
                    end
                end
                FMT_U, FMT_J: begin
                    fmask = 32'h0000_0FFF;
                    fexp  = (32'(e.rd) << 7) | 32'(e.op);
                    if (e.fmt == FMT_U) begin
                        u32  = {w[31:12], 12'h000};
                        dimm = u32;
                    end else begin
                        j21  = {w[31], w[19:12], w[20], w[30:21], 1'b0};
                        dimm = j21;
                    end
                end
                default: ;
            endcase
            checkOutput("rand_fields", w & fmask, fexp);
            if (e.fmt != FMT_R) checkOutput("rand_imm", dimm, e.imm);
        end
    endtask

    // One table vector: accept, then measure latency and compare the word.
    task automatic applyStimulus(input vec_t v, input int idx);
        int guard;
        int lat;
        @(negedge clk);
        driveRec(v.rec);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        checkOutput($sformatf("vec%0d_accept", idx), bus.in_ready, 1'b1);
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            lat++;
        end while (!bus.out_valid && lat < 10);
        checkOutput($sformatf("vec%0d_latency", idx), lat, 2);
        checkOutput($sformatf("vec%0d_inst", idx), bus.out_inst, v.exp_inst);
        checkOutput($sformatf("vec%0d_err", idx), bus.out_err, v.rec.err);
        @(posedge clk);
    endtask

    vec_t        table_q[$];
    rec_t        sb[$];
    rec_t        bp[4];
    logic [31:0] bp_exp[4];

    initial begin
        int          acc;
        int          got;
        int          changes;
        int          cyc;
        int          sent;
        int          ref_err;
        int          extra;
        logic        have;
        logic [31:0] first;
        rec_t        r;
        rec_t        e;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        driveRec(mkRec(4'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 64'd0));

        // ---- reset state ----
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_out_valid", bus.out_valid, 1'b0);
        checkOutput("rst_out_inst", bus.out_inst, 32'h0);
        checkOutput("rst_out_err", bus.out_err, 1'b0);
        rstn = 1'b1;
        #1;
        checkOutput("rst_in_ready", bus.in_ready, 1'b1);

        // ---- directed vector table ----
        table_q.push_back(mkVec(mkRec(FMT_I, OP_IMM, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0, -64'sd1), 32'hFFF1_0093));
        table_q.push_back(mkVec(mkRec(FMT_I, OP_IMM, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0, 64'd2048), 32'h0000_0013));
        table_q.push_back(mkVec(mkRec(FMT_I, OP_IMM, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0, -64'sd2048), 32'h8001_0093));
        table_q.push_back(mkVec(mkRec(FMT_B, OP_BRANCH, 5'd5, 3'd0, 5'd1, 5'd2, 7'd0, -64'sd4), 32'hFE20_8EE3));
        table_q.push_back(mkVec(mkRec(FMT_B, OP_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 64'd3), 32'h0000_0013));
        table_q.push_back(mkVec(mkRec(FMT_U, OP_LUI, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 64'hFFFF_FFFF_8000_0000), 32'h8000_02B7));
        table_q.push_back(mkVec(mkRec(FMT_U, OP_LUI, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 64'h0000_0000_8000_0000), 32'h0000_0013));
        table_q.push_back(mkVec(mkRec(FMT_R, OP_OP, 5'd3, 3'd0, 5'd4, 5'd5, 7'h20, 64'hDEAD_BEEF_0000_DEAD), 32'h4052_01B3));
        table_q.push_back(mkVec(mkRec(4'hF, OP_IMM, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0, 64'd0), 32'h0000_0013));
        table_q.push_back(mkVec(mkRec(FMT_S, OP_STORE, 5'd0, 3'd3, 5'd2, 5'd3, 7'd0, 64'd8), 32'h0031_3423));
        table_q.push_back(mkVec(mkRec(FMT_J, OP_JAL, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 64'd2048), 32'h0010_00EF));
        table_q.push_back(mkVec(mkRec(FMT_J, OP_JAL, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 64'd1048576), 32'h0000_0013));
        table_q.push_back(mkVec(mkRec(FMT_U, OP_LUI, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 64'h1001), 32'h0000_0013));
        table_q.push_back(mkVec(mkRec(FMT_S, OP_STORE, 5'd0, 3'd3, 5'd2, 5'd3, 7'd0, -64'sd2049), 32'h0000_0013));
        table_q.push_back(mkVec(mkRec(FMT_J, OP_JAL, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, -64'sd1048576), 32'h8000_006F));
        table_q.push_back(mkVec(mkRec(FMT_B, OP_BRANCH, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 64'd4094), 32'h7E00_0FE3));
        foreach (table_q[i]) applyStimulus(table_q[i], i);

        // ---- backpressure: 4 back-to-back inputs, consumer stalled 5 cycles ----
        for (int k = 0; k < 4; k++) begin
            bp[k] = mkRec(FMT_I, OP_IMM, 5'(k + 1), 3'd0, 5'(k + 2), 5'd0, 7'd0, 64'(k + 1));
            bp_exp[k] = (32'(k + 1) << 20) | (32'(k + 2) << 15) | (32'(k + 1) << 7) | 32'h13;
        end
        acc = 0; changes = 0; have = 1'b0; first = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            if (acc < 4) begin driveRec(bp[acc]); bus.in_valid = 1'b1; end
            else bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid) begin
                if (!have) begin first = bus.out_inst; have = 1'b1; end
                else if (bus.out_inst !== first) changes++;
            end
            if (bus.in_valid && bus.in_ready) acc++;
        end
        checkOutput("bp_accepts", acc, 2);
        checkOutput("bp_stall_valid", have, 1'b1);
        checkOutput("bp_hold_changes", changes, 0);
        checkOutput("bp_held_inst", first, bp_exp[0]);
        got = 0; cyc = 0;
        while (got < 4 && cyc < 30) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            if (acc < 4) begin driveRec(bp[acc]); bus.in_valid = 1'b1; end
            else bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid) begin
                checkOutput($sformatf("bp_word%0d", got), bus.out_inst, bp_exp[got]);
                got++;
            end
            if (bus.in_valid && bus.in_ready) acc++;
            cyc++;
        end
        checkOutput("bp_count", got, 4);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid) extra++;
        end
        checkOutput("bp_no_dup", extra, 0);

        // ---- reset while words are in flight ----
        @(negedge clk);
        bus.out_ready = 1'b0;
        driveRec(bp[0]);
        bus.in_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("midrst_out_valid", bus.out_valid, 1'b0);
        checkOutput("midrst_out_inst", bus.out_inst, 32'h0);
        checkOutput("midrst_out_err", bus.out_err, 1'b0);
        rstn = 1'b1;
        #1;
        checkOutput("midrst_in_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) extra++;
        end
        checkOutput("midrst_dropped", extra, 0);

        // ---- randomized stream against the decoding reference ----
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        sent = 0; got = 0; cyc = 0; ref_err = 0;
        r = mkRec(4'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 64'd0);
        while (got < 10000 && cyc < 60000) begin
            @(negedge clk);
            if (sent < 10000 && $urandom_range(0, 3) != 0) begin
                r = randRec();
                driveRec(r);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("rand_unexpected_word", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkWord(e);
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(r);
                sent++;
                if (r.err) ref_err++;
            end
            cyc++;
        end
        checkOutput("rand_delivered", got, 10000);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
`ifdef INST_ENC_STATS_EN
        checkOutput("stat_enc", stat_enc, 10000);
        checkOutput("stat_err", stat_err, ref_err);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
